// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared state encoding, default width and counter sizing for booth_seq_mult
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 12;

  // The counter is loaded with w+1, so it needs room for values up to w+1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/cla_adder.sv
// rtl/cla_adder.sv - combinational carry-lookahead adder, 4-bit lookahead groups chained by group carry
module cla_adder #(
  parameter int W = 14
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W-1:0] carry;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry inside a group is a sum-of-products of that group's g/p and the group carry-in.
  always_comb begin
    logic cb;
    logic cc;
    carry = '0;
    cb    = cin;
    for (int base = 0; base < W; base += 4) begin
      cc = cb;
      for (int i = base; (i < W) && (i < base + 4); i++) begin
        carry[i] = cb;
        cc = cb;
        for (int k = base; k < i; k++) begin
          cc = g[k] | (p[k] & cc);
        end
        carry[i] = cc;
        cc = g[i] | (p[i] & cc);
      end
      cb = cc;
    end
  end

  assign sum = p ^ carry;

endmodule

// File: rtl/booth_seq_mult.sv
// rtl/booth_seq_mult.sv - sequential radix-2 Booth multiplier, one step per clock
// Optional BOOTH_UNSIGNED_MODE_EN adds a signed_mode input selecting zero- or sign-extension.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
`ifdef BOOTH_UNSIGNED_MODE_EN
  input  logic                 signed_mode,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int AW = WIDTH + 2;
  localparam int QW = WIDTH + 1;
  localparam int CW = cnt_width(WIDTH);

  state_e               state_q, state_d;
  logic [AW-1:0]        a_q, a_d;
  logic [AW-1:0]        m_q, m_d;
  logic [QW-1:0]        q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic                 sext;
  logic [AW-1:0]        m_ext;
  logic [QW-1:0]        q_ext;
  logic [AW-1:0]        add_b;
  logic                 add_cin;
  logic [AW-1:0]        sum;
  logic [AW-1:0]        a_sh;
  logic [QW-1:0]        q_sh;

`ifdef BOOTH_UNSIGNED_MODE_EN
  assign sext = signed_mode;
`else
  assign sext = 1'b1;
`endif

  assign m_ext = {{2{sext & multiplicand[WIDTH-1]}}, multiplicand};
  assign q_ext = {sext & multiplier[WIDTH-1], multiplier};

  // Subtraction reuses the adder: A - M = A + ~M + 1.
  always_comb begin
    add_b   = '0;
    add_cin = 1'b0;
    case ({q_q[0], qm1_q})
      2'b01:   add_b = m_q;
      2'b10: begin
        add_b   = ~m_q;
        add_cin = 1'b1;
      end
      default: add_b = '0;
    endcase
  end

  cla_adder #(.W(AW)) u_cla_adder (
    .a   (a_q),
    .b   (add_b),
    .cin (add_cin),
    .sum (sum)
  );

  assign a_sh = {sum[AW-1], sum[AW-1:1]};
  assign q_sh = {sum[0], q_q[QW-1:1]};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    m_d       = m_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        done    = (state_q == DONE);
        state_d = IDLE;
        if (start) begin
          state_d = CALC;
          a_d     = '0;
          m_d     = m_ext;
          q_d     = q_ext;
          qm1_d   = 1'b0;
          cnt_d   = CW'(WIDTH + 1);
        end
      end
      CALC: begin
        busy  = 1'b1;
        a_d   = a_sh;
        q_d   = q_sh;
        qm1_d = q_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d   = DONE;
          product_d = {a_sh[WIDTH-2:0], q_sh};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      m_q       <= m_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// tb/tb_booth_seq_mult.sv - self-checking bench for booth_seq_mult (WIDTH=12) against an arithmetic model
module tb_booth_seq_mult;

  localparam int W = 12;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [W-1:0]    multiplicand;
  logic [W-1:0]    multiplier;
  logic            signed_mode;
  logic            busy;
  logic            done;
  logic [2*W-1:0]  product;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  booth_seq_mult #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
`ifdef BOOTH_UNSIGNED_MODE_EN
    .signed_mode  (signed_mode),
`endif
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] m, input logic [W-1:0] q, input bit sm);
    longint mv, qv, pv;
    mv = sm ? longint'($signed(m)) : longint'(m);
    qv = sm ? longint'($signed(q)) : longint'(q);
    pv = mv * qv;
    return pv[2*W-1:0];
  endfunction

  // Called at a negedge; returns at the negedge where done is seen (DONE cycle).
  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q, input bit sm,
                        output logic [2*W-1:0] p, output int lat, output int bcyc, output bit held);
    logic [2*W-1:0] p0;
    p0 = product;
    start = 1'b1; multiplicand = m; multiplier = q; signed_mode = sm;
    @(negedge clk);
    start = 1'b0;
    multiplicand = W'($urandom); multiplier = W'($urandom);
    lat = 0; bcyc = 0; held = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      if (busy) bcyc++;
      if (product !== p0) held = 1'b0;
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
    end
    p = product;
  endtask

  task automatic check_op(input string name, input logic [W-1:0] m, input logic [W-1:0] q, input bit sm,
                          input logic [2*W-1:0] exp_p);
    logic [2*W-1:0] p;
    int lat, bcyc;
    bit held;
    run_op(m, q, sm, p, lat, bcyc, held);
    checks++;
    if (p !== exp_p) begin
      errors++; $display("FAIL %s product: got %h expected %h", name, p, exp_p);
    end
    checks++;
    if (lat != W + 1) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, W + 1);
    end
    checks++;
    if (bcyc != W + 1) begin
      errors++; $display("FAIL %s busy cycles: got %0d expected %0d", name, bcyc, W + 1);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s after done: done=%b busy=%b expected 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0; signed_mode = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      errors++; $display("FAIL reset state: busy=%b done=%b product=%h expected 0 0 0", busy, done, product);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0]   tm [5] = '{12'h007, 12'hFFB, 12'h800, 12'h7FF, 12'h000};
    logic [W-1:0]   tq [5] = '{12'h003, 12'h003, 12'h800, 12'h800, 12'h5A5};
    logic [2*W-1:0] te [5] = '{24'h000015, 24'hFFFFF1, 24'h400000, 24'hC00800, 24'h000000};
    for (int i = 0; i < 5; i++) begin
      check_op($sformatf("directed%0d", i), tm[i], tq[i], 1'b1, te[i]);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] m, q;
    bit sm;
    for (int i = 0; i < 20; i++) begin
      m = W'($urandom); q = W'($urandom);
      sm = 1'b1;
`ifdef BOOTH_UNSIGNED_MODE_EN
      sm = 1'($urandom);
`endif
      check_op($sformatf("random%0d", i), m, q, sm, ref_prod(m, q, sm));
    end
  endtask

  // Ends at the negedge of the DONE cycle so test_back_to_back can restart from DONE.
  task automatic test_ignore_start();
    int lat;
    start = 1'b1; multiplicand = 12'd7; multiplier = 12'd3; signed_mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 5) begin
        start = 1'b1; multiplicand = 12'd100; multiplier = 12'd100;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (lat != W + 1) begin
      errors++; $display("FAIL ignore_start latency: got %0d expected %0d", lat, W + 1);
    end
    checks++;
    if (product !== 24'h000015) begin
      errors++; $display("FAIL ignore_start product: got %h expected 000015", product);
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] p, prev;
    logic [W-1:0] m, q;
    int lat, bcyc;
    bit held;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL b2b entry: done=%b expected 1", done);
    end
    prev = product;
    m = 12'd2; q = 12'd2;
    for (int i = 0; i < 4; i++) begin
      run_op(m, q, 1'b1, p, lat, bcyc, held);
      checks++;
      if (p !== ref_prod(m, q, 1'b1) || lat != W + 1) begin
        errors++; $display("FAIL b2b%0d: product=%h lat=%0d expected %h lat=%0d", i, p, lat, ref_prod(m, q, 1'b1), W + 1);
      end
      checks++;
      if (!held) begin
        errors++; $display("FAIL b2b%0d hold: product left %h before done", i, prev);
      end
      prev = p;
      m = W'($urandom); q = W'($urandom);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    bit seen_done;
    start = 1'b1; multiplicand = 12'd7; multiplier = 12'd3; signed_mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || product === '0) begin
      errors++; $display("FAIL midop precondition: busy=%b product=%h expected busy 1, product nonzero", busy, product);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      errors++; $display("FAIL async reset: busy=%b done=%b product=%h expected 0 0 0", busy, done, product);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin
      errors++; $display("FAIL reset abandon: done or busy seen after reset, expected none");
    end
    check_op("after_reset", 12'd9, 12'd9, 1'b1, 24'h000051);
  endtask

`ifdef BOOTH_UNSIGNED_MODE_EN
  task automatic test_unsigned();
    check_op("unsigned_fff", 12'hFFF, 12'hFFF, 1'b0, 24'hFFE001);
    check_op("signed_fff", 12'hFFF, 12'hFFF, 1'b1, 24'h000001);
    check_op("unsigned_800", 12'h800, 12'h800, 1'b0, 24'h400000);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_midop();
`ifdef BOOTH_UNSIGNED_MODE_EN
    test_unsigned();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/booth_seq_mult.md
BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 SHALL have parameter WIDTH, default 12, giving the operand width in bits; the legal range is 4..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request a multiply; sampled on the rising edge of clk.
REQ-005 SHALL have port multiplicand, input, WIDTH bits: operand M, captured when start is accepted.
REQ-006 SHALL have port multiplier, input, WIDTH bits: operand Q, captured when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: high while an operation is iterating.
REQ-008 SHALL have port done, output, 1 bit: a one-cycle pulse marking that product is valid.
REQ-009 SHALL have port product, output, 2*WIDTH bits: the registered result, held until the next accepted start.

Function
REQ-010 SHALL implement the states IDLE, CALC and DONE.
REQ-011 SHALL move IDLE->CALC when start=1; SHALL move CALC->DONE when the iteration count reaches 0; SHALL move DONE->CALC if start=1, otherwise DONE->IDLE.
REQ-012 SHALL accept start only in IDLE or DONE; start in CALC SHALL be ignored, with no operand capture and no effect on the running result.
REQ-013 SHALL, on acceptance, sign-extend M and Q to WIDTH+1 bits, clear the accumulator A (WIDTH+2 bits) and Q-1, and load the iteration count with WIDTH+1.
REQ-014 SHALL perform one radix-2 Booth step per CALC cycle: {Q0,Q-1}=01 gives A+=M; 10 gives A-=M; 00/11 gives no add; then an arithmetic right shift of {A,Q,Q-1}.
REQ-015 SHALL form A-M as A + ~M + 1 through the adder carry-in, never with a separate subtractor.
REQ-016 SHALL register product as the low 2*WIDTH bits of the final {A,Q} on the CALC->DONE edge; the result SHALL be exact for all operand pairs, including (-2^(WIDTH-1))^2.
REQ-017 SHALL assert done exactly WIDTH+1 edges after the edge that accepts start, for exactly one cycle (13 edges when WIDTH=12).
REQ-018 SHALL hold busy=1 only in CALC; busy SHALL be 0 in IDLE and DONE.
REQ-019 SHALL support back-to-back operation: a start accepted in DONE restarts immediately, and product keeps the previous result until the new one is written.

Reset
REQ-020 SHALL, on rst_n=0, set state to IDLE and clear busy, done, product, A, Q, Q-1 and the count, immediately and independent of clk.
REQ-021 SHALL abandon any in-flight operation on reset with no done pulse; the first operation after reset release SHALL complete correctly.

Configuration
REQ-022 SHALL support the macro BOOTH_UNSIGNED_MODE_EN; when it is defined, an input port signed_mode (1 bit) SHALL exist, and signed_mode=0 SHALL zero-extend both operands instead of sign-extending them; latency SHALL be unchanged.
REQ-023 SHALL, when BOOTH_UNSIGNED_MODE_EN is undefined, have no signed_mode port and always treat operands as signed two's complement.

Structure
REQ-024 SHALL take the state encoding typedef, the default WIDTH constant and the iteration-count width function from the shared package booth_pkg.
REQ-025 SHALL instantiate one sub-module, cla_adder, a combinational carry-lookahead adder of parameter width W (here WIDTH+2) with ports a, b, cin and sum, used for every Booth add and subtract.

Verification
All scenarios use WIDTH=12.
REQ-026 SHALL cover: M=7, Q=3 -> product=0x000015, with done on edge 13 after start and busy high for 13 cycles.
REQ-027 SHALL cover: M=-5 (0xFFB), Q=3 -> product=0xFFFFF1.
REQ-028 SHALL cover: M=Q=-2048 (0x800) -> product=0x400000.
REQ-029 SHALL cover: start with 7x3, then start pulsed at cycle 5 with 100x100 -> the second request is ignored and product=0x000015; a start in the DONE cycle with 2x2 -> product=0x000004 after 13 more edges.
REQ-030 SHALL cover: rst_n driven low at cycle 6 of an operation -> busy=0, done=0 and product=0 immediately; after release, 9x9 -> product=0x000051.
REQ-031 SHALL cover, with BOOTH_UNSIGNED_MODE_EN defined: signed_mode=0, M=Q=0xFFF -> product=0xFFE001; signed_mode=1 with the same operands -> product=0x000001.
